sdr_wb_arbiter: RTL and testbench
=================================

# sdr_wb_arbiter

Two-master Wishbone arbiter that shares the single Wishbone slave port of the SDRAM controller (`wb_*_i`/`wb_*_o`) between two requesters, e.g. CPU and DMA. It sits directly in front of the controller on the `sys_clk` domain. Arbitration is round-robin at transaction granularity: a grant is held for the whole `cyc` assertion, so bursts (`cti`) are never split. A watchdog releases a grant that stalls without `ack`.

## Interface

Parameters:

- `AW`, 26: Wishbone address width; matches `aw`.
- `DW`, 32: Wishbone data width; matches `dw`. Select width is `DW/8`.
- `TO_CYCLES`, 1024: stall cycles (stb high, no ack) before forced release; legal range 2..65535.

Ports:

- `sys_clk` input 1: clock, rising edge.
- `RESETN` input 1: asynchronous active-low reset.
- Master inputs, for x in {0,1}:
  - `mx_cyc_i`, `mx_stb_i`, `mx_we_i`: input 1 each.
  - `mx_addr_i` input AW; `mx_dat_i` input DW; `mx_sel_i` input DW/8; `mx_cti_i` input 3.
- Master outputs, for x in {0,1}:
  - `mx_ack_o` output 1; `mx_err_o` output 1; `mx_dat_o` output DW.
- Controller side:
  - `wb_cyc_o`, `wb_stb_o`, `wb_we_o` output 1 each.
  - `wb_addr_o` output AW; `wb_dat_o` output DW; `wb_sel_o` output DW/8; `wb_cti_o` output 3.
  - `wb_ack_i` input 1; `wb_dat_i` input DW.
- `grant_o` output 2: one-hot current grant; 00 when idle.

## Operation

- FSM states: IDLE, G0, G1. Registered state; `last` register records the last granted master.
- Reset: state IDLE, `last`=1 (m0 wins the first tie), watchdog 0, `grant_o`=00. All `wb_*_o`, `mx_ack_o` and `mx_err_o` are 0.
- IDLE transitions:
  - Only m0_cyc → G0. Only m1_cyc → G1.
  - Both → the master ≠ `last`.
  - Neither → stay IDLE.
- G0 transitions (G1 is symmetric):
  - `m0_cyc_i`=1 → stay.
  - `m0_cyc_i`=0 and `m1_cyc_i`=1 → G1 directly, with no idle cycle.
  - `m0_cyc_i`=0 and `m1_cyc_i`=0 → IDLE.
  - `last` is updated to the granted index on every entry to G0 or G1.
- Slave mux (combinational from state):
  - In Gx, all `wb_*_o` = master x signals, and `wb_cyc_o`/`wb_stb_o` are ANDed with `mx_cyc_i`.
  - In IDLE, `wb_cyc_o`=`wb_stb_o`=0 and the other outputs are 0.
- Return path:
  - `mx_ack_o` = `wb_ack_i` && state==Gx. The non-granted master always sees ack=0.
  - `m0_dat_o` = `m1_dat_o` = `wb_dat_i`. Data is broadcast; qualified by ack.
- Watchdog (16-bit counter):
  - Cleared on `wb_ack_i`, on `wb_stb_o`=0, and on any state change.
  - Increments while `wb_stb_o`=1 and `wb_ack_i`=0.
  - On reaching TO_CYCLES-1 with stall still present: `mx_err_o` pulses one cycle for the granted master, and the next state is IDLE, even if `mx_cyc_i` is still high.
- After a forced release, master x is not re-granted until it drops `cyc` for at least one cycle. A per-master `blocked` flag is set on the timeout and cleared on `cyc`=0.
- `ack` and timeout on the same cycle: ack wins. The counter clears and no err is raised.
- Reset mid-burst: outputs go to reset values immediately (asynchronous). Burst state is discarded.

## Timing

- Grant latency: `cyc` rising in IDLE → `wb_cyc_o` high on the next `sys_clk` edge (1 cycle).
- Handover: Gx→Gy with zero dead cycles when y is waiting as x drops `cyc`.
- Forwarding: `wb_*_o` and `mx_ack_o` are combinational through the mux; there is no added latency per beat.
- `grant_o` equals the registered state.
- Error timing: `mx_err_o` is high exactly in cycle TO_CYCLES of stall, counted from the first stalled stb cycle.
- `wb_cti_o` is passed through unchanged; the arbiter never terminates a burst except by timeout.

## Test plan

- Reset, then m0 single write (addr 0x10, dat 0xDEADBEEF, sel F): `grant_o`=01 one cycle after cyc; `wb_addr_o`=0x10; `m0_ack_o` follows `wb_ack_i`; `m1_ack_o` stays 0.
- m0 and m1 raise cyc on the same cycle after reset: m0 is granted first. When m0 drops cyc, G1 is entered on the next edge with no IDLE cycle. The next simultaneous tie goes to m0 (`last`=1).
- m0 does an 8-beat incrementing burst (cti 010…111) while m1 requests: all 8 acks go to m0 with no interleave. m1 is granted after m0's cyc falls.
- Stall with TO_CYCLES=16: slave never acks m1 → `m1_err_o` pulses at stall cycle 16, state goes IDLE, and m1 is not re-granted until its cyc toggles low. m0 is served meanwhile.
- Ack on the exact timeout cycle (cycle 16): no err; the transfer completes normally.
- Assert `RESETN`=0 mid-burst in G1: `wb_cyc_o`, `wb_stb_o` and `grant_o` drop asynchronously. After release, the first tie goes to m0.

Source files
------------

// File: rtl/sdr_wb_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the SDRAM controller slave port.
// Grants are held for a whole cyc assertion; a stall watchdog force-releases a hung grant.
module sdr_wb_arbiter #(
    parameter int unsigned AW        = 26,
    parameter int unsigned DW        = 32,
    parameter int unsigned TO_CYCLES = 1024
) (
    input  logic              sys_clk,
    input  logic              RESETN,
    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    input  logic              m0_we_i,
    input  logic [AW-1:0]     m0_addr_i,
    input  logic [DW-1:0]     m0_dat_i,
    input  logic [DW/8-1:0]   m0_sel_i,
    input  logic [2:0]        m0_cti_i,
    output logic              m0_ack_o,
    output logic              m0_err_o,
    output logic [DW-1:0]     m0_dat_o,
    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    input  logic              m1_we_i,
    input  logic [AW-1:0]     m1_addr_i,
    input  logic [DW-1:0]     m1_dat_i,
    input  logic [DW/8-1:0]   m1_sel_i,
    input  logic [2:0]        m1_cti_i,
    output logic              m1_ack_o,
    output logic              m1_err_o,
    output logic [DW-1:0]     m1_dat_o,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [AW-1:0]     wb_addr_o,
    output logic [DW-1:0]     wb_dat_o,
    output logic [DW/8-1:0]   wb_sel_o,
    output logic [2:0]        wb_cti_o,
    input  logic              wb_ack_i,
    input  logic [DW-1:0]     wb_dat_i,
    output logic [1:0]        grant_o
);

    localparam int unsigned WDW = 16;
    localparam logic [WDW-1:0] WD_LAST = WDW'(TO_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic           last;
    logic [1:0]     blocked;
    logic [WDW-1:0] wd_cnt;
    logic           req0;
    logic           req1;
    logic           stall;
    logic           timeout;

    // A master that was force-released must drop cyc before it may compete again
    assign req0 = m0_cyc_i && !blocked[0];
    assign req1 = m1_cyc_i && !blocked[1];

    // Slave-side mux, selected by the registered grant
    always_comb begin
        wb_cyc_o  = 1'b0;
        wb_stb_o  = 1'b0;
        wb_we_o   = 1'b0;
        wb_addr_o = '0;
        wb_dat_o  = '0;
        wb_sel_o  = '0;
        wb_cti_o  = 3'b000;
        case (state)
            G0: begin
                wb_cyc_o  = m0_cyc_i;
                wb_stb_o  = m0_stb_i && m0_cyc_i;
                wb_we_o   = m0_we_i;
                wb_addr_o = m0_addr_i;
                wb_dat_o  = m0_dat_i;
                wb_sel_o  = m0_sel_i;
                wb_cti_o  = m0_cti_i;
            end
            G1: begin
                wb_cyc_o  = m1_cyc_i;
                wb_stb_o  = m1_stb_i && m1_cyc_i;
                wb_we_o   = m1_we_i;
                wb_addr_o = m1_addr_i;
                wb_dat_o  = m1_dat_i;
                wb_sel_o  = m1_sel_i;
                wb_cti_o  = m1_cti_i;
            end
            default: ;
        endcase
    end

    // Ack beats the timeout when both land on the same cycle
    assign stall   = wb_stb_o && !wb_ack_i;
    assign timeout = stall && (wd_cnt == WD_LAST);

    assign m0_ack_o = wb_ack_i && (state == G0);
    assign m1_ack_o = wb_ack_i && (state == G1);
    assign m0_err_o = timeout && (state == G0);
    assign m1_err_o = timeout && (state == G1);
    assign m0_dat_o = wb_dat_i;
    assign m1_dat_o = wb_dat_i;
    assign grant_o  = {state == G1, state == G0};

    // Next-state: round-robin on ties, direct handover when the other master waits
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req0 && req1) begin
                    state_nxt = last ? G0 : G1;
                end else if (req0) begin
                    state_nxt = G0;
                end else if (req1) begin
                    state_nxt = G1;
                end
            end
            G0: begin
                if (timeout) begin
                    state_nxt = IDLE;
                end else if (!m0_cyc_i) begin
                    state_nxt = req1 ? G1 : IDLE;
                end
            end
            G1: begin
                if (timeout) begin
                    state_nxt = IDLE;
                end else if (!m1_cyc_i) begin
                    state_nxt = req0 ? G0 : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge RESETN) begin
        if (!RESETN) begin
            state   <= IDLE;
            last    <= 1'b1;
            blocked <= 2'b00;
            wd_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt == G0) begin
                last <= 1'b0;
            end else if (state_nxt == G1) begin
                last <= 1'b1;
            end
            if (timeout && (state == G0)) begin
                blocked[0] <= 1'b1;
            end else if (!m0_cyc_i) begin
                blocked[0] <= 1'b0;
            end
            if (timeout && (state == G1)) begin
                blocked[1] <= 1'b1;
            end else if (!m1_cyc_i) begin
                blocked[1] <= 1'b0;
            end
            if ((state_nxt != state) || !stall) begin
                wd_cnt <= '0;
            end else begin
                wd_cnt <= wd_cnt + WDW'(1);
            end
        end
    end

endmodule

// File: tb/tb_sdr_wb_arbiter.sv
// Directed bench for sdr_wb_arbiter with a 16-cycle watchdog; expectations are hand-derived.
module tb_sdr_wb_arbiter;

    localparam int unsigned AW = 26;
    localparam int unsigned DW = 32;

    logic            sys_clk;
    logic            RESETN;
    logic            m0_cyc_i, m0_stb_i, m0_we_i;
    logic [AW-1:0]   m0_addr_i;
    logic [DW-1:0]   m0_dat_i;
    logic [DW/8-1:0] m0_sel_i;
    logic [2:0]      m0_cti_i;
    logic            m0_ack_o, m0_err_o;
    logic [DW-1:0]   m0_dat_o;
    logic            m1_cyc_i, m1_stb_i, m1_we_i;
    logic [AW-1:0]   m1_addr_i;
    logic [DW-1:0]   m1_dat_i;
    logic [DW/8-1:0] m1_sel_i;
    logic [2:0]      m1_cti_i;
    logic            m1_ack_o, m1_err_o;
    logic [DW-1:0]   m1_dat_o;
    logic            wb_cyc_o, wb_stb_o, wb_we_o;
    logic [AW-1:0]   wb_addr_o;
    logic [DW-1:0]   wb_dat_o;
    logic [DW/8-1:0] wb_sel_o;
    logic [2:0]      wb_cti_o;
    logic            wb_ack_i;
    logic [DW-1:0]   wb_dat_i;
    logic [1:0]      grant_o;

    int n_cmp = 0;
    int n_err = 0;

    sdr_wb_arbiter #(.AW(AW), .DW(DW), .TO_CYCLES(16)) dut (
        .sys_clk(sys_clk), .RESETN(RESETN),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
        .m0_addr_i(m0_addr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_cti_i(m0_cti_i),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_dat_o(m0_dat_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
        .m1_addr_i(m1_addr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_cti_i(m1_cti_i),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_dat_o(m1_dat_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_addr_o(wb_addr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_cti_o(wb_cti_o),
        .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i), .grant_o(grant_o)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge; checks follow 1 unit later
    task automatic tick();
        @(posedge sys_clk);
        #2;
    endtask

    task automatic drop_all();
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        wb_ack_i = 1'b0;
    endtask

    initial begin
        RESETN = 1'b0;
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_we_i = 1'b0;
        m0_addr_i = '0; m0_dat_i = '0; m0_sel_i = '0; m0_cti_i = 3'b000;
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0;
        m1_addr_i = 26'h200; m1_dat_i = 32'h11112222; m1_sel_i = 4'h3; m1_cti_i = 3'b000;
        wb_ack_i = 1'b0; wb_dat_i = '0;

        // Reset state
        repeat (2) @(posedge sys_clk);
        #2;
        chk2("rst_grant", grant_o, 2'b00);
        chk1("rst_wb_cyc", wb_cyc_o, 1'b0);
        chk1("rst_wb_stb", wb_stb_o, 1'b0);
        chk1("rst_m0_ack", m0_ack_o, 1'b0);
        chk1("rst_m0_err", m0_err_o, 1'b0);
        chk1("rst_m1_err", m1_err_o, 1'b0);
        RESETN = 1'b1;
        tick();

        // m0 single write
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b1;
        m0_addr_i = 26'h10; m0_dat_i = 32'hDEADBEEF; m0_sel_i = 4'hF; m0_cti_i = 3'b000;
        #1;
        chk2("wr_grant_pre", grant_o, 2'b00);
        chk1("wr_cyc_pre", wb_cyc_o, 1'b0);
        tick();
        wb_ack_i = 1'b1; wb_dat_i = 32'h5A5A0001;
        #1;
        chk2("wr_grant", grant_o, 2'b01);
        chk1("wr_wb_cyc", wb_cyc_o, 1'b1);
        chk32("wr_addr", 32'(wb_addr_o), 32'h10);
        chk32("wr_dat", wb_dat_o, 32'hDEADBEEF);
        chk1("wr_we", wb_we_o, 1'b1);
        chk2("wr_sel_lo", wb_sel_o[1:0], 2'b11);
        chk1("wr_m0_ack", m0_ack_o, 1'b1);
        chk1("wr_m1_ack", m1_ack_o, 1'b0);
        chk32("wr_m0_rdat", m0_dat_o, 32'h5A5A0001);
        tick();
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; wb_ack_i = 1'b0;
        #1;
        chk1("wr_ack_drop", m0_ack_o, 1'b0);
        chk1("wr_cyc_gated", wb_cyc_o, 1'b0);
        tick();
        #1;
        chk2("wr_idle", grant_o, 2'b00);

        // Tie right after reset goes to m0, then direct handover to m1
        RESETN = 1'b0;
        tick();
        RESETN = 1'b1;
        tick();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        tick();
        wb_ack_i = 1'b1;
        #1;
        chk2("tie1_grant", grant_o, 2'b01);
        chk1("tie1_m0_ack", m0_ack_o, 1'b1);
        chk1("tie1_m1_ack", m1_ack_o, 1'b0);
        tick();
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; wb_ack_i = 1'b0;
        #1;
        chk2("tie1_hold", grant_o, 2'b01);
        tick();
        #1;
        chk2("handover", grant_o, 2'b10);
        chk32("handover_addr", 32'(wb_addr_o), 32'h200);
        chk1("handover_we", wb_we_o, 1'b0);
        wb_ack_i = 1'b1;
        #1;
        chk1("h_m1_ack", m1_ack_o, 1'b1);
        chk1("h_m0_ack", m0_ack_o, 1'b0);
        tick();
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0; wb_ack_i = 1'b0;
        tick();
        #1;
        chk2("h_idle", grant_o, 2'b00);
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        tick();
        #1;
        chk2("tie2_grant", grant_o, 2'b01);
        drop_all();
        tick();
        tick();
        #1;
        chk2("tie2_idle", grant_o, 2'b00);

        // m0 8-beat incrementing burst with m1 waiting
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b1;
        m0_addr_i = 26'h100; m0_cti_i = 3'b010;
        tick();
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; wb_ack_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick();
            m0_addr_i = 26'(32'h100 + 32'(4 * i));
            m0_cti_i = (i == 7) ? 3'b111 : 3'b010;
            #1;
            chk1("burst_m0_ack", m0_ack_o, 1'b1);
            chk1("burst_m1_ack", m1_ack_o, 1'b0);
            chk32("burst_addr", 32'(wb_addr_o), 32'h100 + 32'(4 * i));
            chk32("burst_cti", 32'(wb_cti_o), (i == 7) ? 32'h7 : 32'h2);
        end
        tick();
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; wb_ack_i = 1'b0;
        #1;
        chk2("burst_hold", grant_o, 2'b01);
        tick();
        #1;
        chk2("burst_to_m1", grant_o, 2'b10);

        // m1 stalls; watchdog fires in stall cycle 16 while m0 waits
        for (int k = 1; k <= 16; k++) begin
            if (k > 1) tick();
            if (k == 10) begin
                m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_addr_i = 26'h20; m0_cti_i = 3'b000;
            end
            #1;
            chk1("stall_m1_err", m1_err_o, (k == 16) ? 1'b1 : 1'b0);
        end
        chk2("stall_grant", grant_o, 2'b10);
        chk1("stall_m0_err", m0_err_o, 1'b0);
        tick();
        #1;
        chk2("to_idle", grant_o, 2'b00);
        chk1("to_err_clear", m1_err_o, 1'b0);
        tick();
        #1;
        chk2("m0_served", grant_o, 2'b01);
        wb_ack_i = 1'b1;
        #1;
        chk1("served_m0_ack", m0_ack_o, 1'b1);
        chk1("served_m1_ack", m1_ack_o, 1'b0);
        tick();
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; wb_ack_i = 1'b0;
        tick();
        tick();
        #1;
        chk2("m1_blocked", grant_o, 2'b00);
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        tick();
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        tick();
        #1;
        chk2("m1_regrant", grant_o, 2'b10);
        wb_ack_i = 1'b1;
        #1;
        chk1("regrant_ack", m1_ack_o, 1'b1);
        tick();
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0; wb_ack_i = 1'b0;
        tick();
        #1;
        chk2("regrant_idle", grant_o, 2'b00);

        // Ack arriving on the exact timeout cycle completes normally
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        tick();
        for (int k = 1; k <= 16; k++) begin
            if (k > 1) tick();
            if (k == 16) wb_ack_i = 1'b1;
            #1;
            if (k == 15) chk1("ackto_err15", m1_err_o, 1'b0);
        end
        chk1("ackto_err16", m1_err_o, 1'b0);
        chk1("ackto_ack", m1_ack_o, 1'b1);
        chk2("ackto_grant", grant_o, 2'b10);
        tick();
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0; wb_ack_i = 1'b0;
        #1;
        chk2("ackto_stay", grant_o, 2'b10);
        chk1("ackto_no_err", m1_err_o, 1'b0);
        tick();
        #1;
        chk2("ackto_idle", grant_o, 2'b00);

        // Asynchronous reset in the middle of an m1 burst
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_cti_i = 3'b010;
        tick();
        wb_ack_i = 1'b1;
        #1;
        chk2("mid_grant", grant_o, 2'b10);
        chk1("mid_cyc", wb_cyc_o, 1'b1);
        RESETN = 1'b0;
        #1;
        chk1("arst_cyc", wb_cyc_o, 1'b0);
        chk1("arst_stb", wb_stb_o, 1'b0);
        chk2("arst_grant", grant_o, 2'b00);
        chk1("arst_m1_ack", m1_ack_o, 1'b0);
        drop_all();
        tick();
        RESETN = 1'b1;
        tick();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        tick();
        #1;
        chk2("post_rst_tie", grant_o, 2'b01);
        drop_all();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
